// File: rtl/cp_pkg.sv
// Shared definitions for cp_pipe: controller state encodings and the
// occupancy counter width helper.
package cp_pkg;

  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_WAIT = 2'd2
  } out_state_t;

  function automatic int occ_width(input int depth);
    return ($clog2(depth + 1) > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/cp_stage.sv
// One pipeline stage: a full flag and a WIDTH-bit data latch.
// Load wins over release; the pipe never asserts both in one cycle.
module cp_stage #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_rel,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Full flag: set on load, cleared on release or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_rel) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  // Data latch: only meaningful while the full flag is set, so it has no reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/cp_pipe.sv
// cp_pipe: DEPTH-stage 4-phase handshake pipeline, one token per stage.
// Define CP_PIPE_OCC_EN to add the registered occupancy output occ.
module cp_pipe
  import cp_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] data_out
`ifdef CP_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  in_state_t        r_in_state;
  in_state_t        w_in_next;
  out_state_t       r_out_state;
  out_state_t       w_out_next;
  logic             r_in_ack;
  logic             r_out_req;
  logic [WIDTH-1:0] r_data_out;

  logic [DEPTH-1:0] w_full;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_rel;
  logic [WIDTH-1:0] w_din  [DEPTH];
  logic [WIDTH-1:0] w_data [DEPTH];

  logic w_capture;
  logic w_out_rel;
  logic w_out_fire;

  // All transfer decisions look only at full flags registered last edge.
  assign w_capture  = (r_in_state == IN_IDLE) && in_req && !w_full[0];
  assign w_out_rel  = (r_out_state == OUT_REQ) && out_ack;
  assign w_out_fire = (r_out_state == OUT_IDLE) && w_full[DEPTH-1] && !out_ack;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_load[gi] = w_capture;
        assign w_din[gi]  = data_in;
      end else begin : g_mid
        assign w_load[gi] = w_full[gi-1] && !w_full[gi];
        assign w_din[gi]  = w_data[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_last
        assign w_rel[gi] = w_out_rel;
      end else begin : g_inner
        assign w_rel[gi] = w_full[gi] && !w_full[gi+1];
      end

      cp_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_load[gi]),
        .i_rel (w_rel[gi]),
        .i_data(w_din[gi]),
        .o_full(w_full[gi]),
        .o_data(w_data[gi])
      );
    end
  endgenerate

  // Input controller state register and registered acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_state <= IN_IDLE;
      r_in_ack   <= 1'b0;
    end else begin
      r_in_state <= w_in_next;
      r_in_ack   <= (w_in_next == IN_ACK);
    end
  end

  // Input controller next state.
  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      IN_IDLE: begin
        if (w_capture) begin
          w_in_next = IN_ACK;
        end else begin
          w_in_next = IN_IDLE;
        end
      end
      IN_ACK: begin
        if (!in_req) begin
          w_in_next = IN_IDLE;
        end else begin
          w_in_next = IN_ACK;
        end
      end
      default: w_in_next = IN_IDLE;
    endcase
  end

  // Output controller state register, request and data output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= OUT_IDLE;
      r_out_req   <= 1'b0;
      r_data_out  <= {WIDTH{1'b0}};
    end else begin
      r_out_state <= w_out_next;
      r_out_req   <= (w_out_next == OUT_REQ);
      if (w_out_fire) begin
        r_data_out <= w_data[DEPTH-1];
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

  // Output controller next state; an ack seen in OUT_IDLE is ignored.
  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      OUT_IDLE: begin
        if (w_out_fire) begin
          w_out_next = OUT_REQ;
        end else begin
          w_out_next = OUT_IDLE;
        end
      end
      OUT_REQ: begin
        if (out_ack) begin
          w_out_next = OUT_WAIT;
        end else begin
          w_out_next = OUT_REQ;
        end
      end
      OUT_WAIT: begin
        if (!out_ack) begin
          w_out_next = OUT_IDLE;
        end else begin
          w_out_next = OUT_WAIT;
        end
      end
      default: w_out_next = OUT_IDLE;
    endcase
  end

  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign data_out = r_data_out;

`ifdef CP_PIPE_OCC_EN
  localparam int               OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);

  logic [OCC_W-1:0] r_occ;

  // Occupancy: +1 on capture, -1 on downstream release, unchanged on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= {OCC_W{1'b0}};
    end else if (w_capture && !w_out_rel) begin
      r_occ <= r_occ + OCC_ONE;
    end else if (!w_capture && w_out_rel) begin
      r_occ <= r_occ - OCC_ONE;
    end else begin
      r_occ <= r_occ;
    end
  end

  assign occ = r_occ;
`endif

endmodule
